mult_bus_sequencer: RTL and testbench
=====================================

// Module: mult_bus_sequencer
// PURPOSE
//  Bus-master front end for the gpioemu multiplier/popcount peripheral.
//  Takes 24x24 operand pairs from a valid/ready stream and writes A1 (0x0380)
//  and A2 (0x0388). Starts the peripheral (0x03A0) and polls its status.
//  Reads W (0x0390) and L (0x0398) and returns them on a valid/ready result stream.
// PARAMETERS
//  ADDR_A1    16'h0380  address of operand A1
//  ADDR_A2    16'h0388  address of operand A2
//  ADDR_W     16'h0390  address of product word W (low 32 bits)
//  ADDR_L     16'h0398  address of popcount L
//  ADDR_CTRL  16'h03A0  start (write) / status B[1:0] (read)
//  POLL_GAP   4         idle cycles before each status poll (>=1)
//  POLL_MAX   64        max status polls before timeout (>=1)
// PORTS
//  clk        in   1   clock, all state on rising edge
//  n_reset    in   1   asynchronous, active-low reset
//  op_valid   in   1   operand pair valid
//  op_ready   out  1   sequencer can accept operands
//  op_a       in   24  operand A -> A1
//  op_b       in   24  operand B -> A2
//  res_valid  out  1   result valid
//  res_ready  in   1   consumer accepts result
//  res_w      out  32  product low word
//  res_l      out  6   popcount of product low word (0..32)
//  res_tout   out  1   1 = peripheral never reported done
//  busy       out  1   high in any state other than IDLE
//  saddress   out  16  peripheral address
//  swr        out  1   write strobe (peripheral samples on rising edge)
//  srd        out  1   read strobe (peripheral updates sdata on rising edge)
//  sdata_wr   out  32  write data to peripheral
//  sdata_rd   in   32  read data from peripheral
// BEHAVIOUR
//  Reset values (async, while n_reset=0):
//   - Outputs 0: state, counters, swr, srd, saddress, sdata_wr, res_*, busy.
//   - op_ready=1.
//  Accept: op_valid&&op_ready at an edge captures op_a/op_b; op_ready=1 only in IDLE.
//  Bus access = 3 cycles; saddress/sdata_wr stable through all three:
//   - SETUP: strobe 0.
//   - STROBE: strobe 1 for exactly one cycle.
//   - HOLD: strobe 0; reads capture sdata_rd at the end of HOLD.
//   - swr and srd are never high together.
//  States:
//   IDLE -> WR_A1 ({8'h0,op_a}) -> WR_A2 ({8'h0,op_b}) -> WR_GO (ADDR_CTRL, data 0)
//   -> GAP (POLL_GAP cycles) -> POLL (read ADDR_CTRL)
//   POLL: status sdata_rd[1:0]==2'b11 -> RD_W; else poll_cnt+1
//     - poll_cnt<POLL_MAX -> GAP;
//     - POLL_MAX-th poll not done -> OUT with res_tout=1, res_w=0, res_l=0.
//   RD_W (read ADDR_W -> res_w) -> RD_L (read ADDR_L, res_l=sdata_rd[5:0]) -> OUT
//   OUT: res_valid=1; outputs held stable until res_valid&&res_ready, then IDLE.
//  Latency:
//   - Done on first poll: res_valid rises at edge 18+POLL_GAP after accepting edge.
//   - Each extra poll adds POLL_GAP+3 cycles.
//  Backpressure: res_ready low stalls in OUT indefinitely; no new op accepted.
//  Back-to-back: op_ready rises the cycle after result handshake (IDLE >=1 cycle).
//  poll_cnt cleared on each accept; width clog2(POLL_MAX+1).
//  Reset mid-operation:
//   - Any state -> IDLE immediately; strobes drop to 0.
//   - Pending result discarded; peripheral not re-written.
// CONFIGURATION
//  SEQ_PERF_EN defined: adds outputs perf_ops[15:0] and perf_tout[15:0].
//   - perf_ops +1 on each handshake with res_tout=0; perf_tout +1 on each with res_tout=1.
//   - Both wrap at 16'hFFFF->0 and reset to 0.
//  SEQ_PERF_EN undefined: ports and counters absent; all else identical.
// TESTING
//  1 n_reset=0 mid-run -> strobes 0, op_ready=1, res_valid=0, busy=0 asynchronously.
//  2 a=3,b=5, peripheral model:
//    - writes: 0x0380<=3, 0x0388<=5, 0x03A0.
//    - reads: status, then 0x0390, 0x0398.
//    - res_w=15, res_l=4, res_tout=0.
//  3 a=b=24'hFFFFFF -> res_w=32'hFE000001, res_l=8, res_tout=0.
//  4 status held at 2'b01:
//    - exactly POLL_MAX(64) reads of 0x03A0, no reads of 0x0390/0x0398.
//    - res_tout=1, res_w=0.
//  5 res_ready low 10 cycles in OUT:
//    - res_* stable, op_ready=0.
//    - second op (a=2,b=7) accepted only after handshake -> res_w=14, res_l=3.
//  6 SEQ_PERF_EN, run test 2 then test 4 -> perf_ops=1, perf_tout=1.

Source files
------------

// File: rtl/mult_bus_sequencer_if.sv
// ----------------------------------------------------------------------------
// mult_bus_sequencer_if
// Signals between the multiplier bus sequencer and its surroundings: the
// operand stream, the result stream and the peripheral bus.
//   op_valid/op_ready/op_a/op_b          operand stream (into the sequencer)
//   res_valid/res_ready/res_w/res_l/
//   res_tout                             result stream (out of the sequencer)
//   saddress/swr/srd/sdata_wr/sdata_rd   peripheral bus
// Modports:
//   master : the sequencer side
//   slave  : the environment side (operand source, result sink, peripheral)
// ----------------------------------------------------------------------------
interface mult_bus_sequencer_if;
    logic        op_valid;
    logic        op_ready;
    logic [23:0] op_a;
    logic [23:0] op_b;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_w;
    logic [5:0]  res_l;
    logic        res_tout;
    logic [15:0] saddress;
    logic        swr;
    logic        srd;
    logic [31:0] sdata_wr;
    logic [31:0] sdata_rd;

    modport master (
        input  op_valid, op_a, op_b, res_ready, sdata_rd,
        output op_ready, res_valid, res_w, res_l, res_tout,
               saddress, swr, srd, sdata_wr
    );

    modport slave (
        output op_valid, op_a, op_b, res_ready, sdata_rd,
        input  op_ready, res_valid, res_w, res_l, res_tout,
               saddress, swr, srd, sdata_wr
    );
endinterface

// File: rtl/mult_bus_sequencer.sv
// ----------------------------------------------------------------------------
// mult_bus_sequencer
// Bus-master front end for the gpioemu multiplier/popcount peripheral.
// Accepts a 24x24 operand pair, writes A1 and A2, starts the peripheral,
// polls its status every POLL_GAP idle cycles (at most POLL_MAX polls), then
// reads the product low word W and its popcount L and presents them on the
// result stream. If the peripheral never reports done, a result with
// res_tout=1 and zero data is presented instead.
// Ports:
//   clk        clock, all state on the rising edge
//   n_reset    asynchronous active-low reset
//   bus        mult_bus_sequencer_if.master (operand/result streams, bus)
//   busy       high whenever the sequencer is not idle
//   perf_ops   (SEQ_PERF_EN only) successful results delivered, wraps
//   perf_tout  (SEQ_PERF_EN only) timed-out results delivered, wraps
// Optional feature: define SEQ_PERF_EN to add the two performance counters.
// Every bus access takes three cycles (setup, strobe, hold) with address and
// write data stable throughout; read data is captured at the end of hold.
// ----------------------------------------------------------------------------
module mult_bus_sequencer #(
    parameter logic [15:0] ADDR_A1   = 16'h0380,
    parameter logic [15:0] ADDR_A2   = 16'h0388,
    parameter logic [15:0] ADDR_W    = 16'h0390,
    parameter logic [15:0] ADDR_L    = 16'h0398,
    parameter logic [15:0] ADDR_CTRL = 16'h03A0,
    parameter int          POLL_GAP  = 4,
    parameter int          POLL_MAX  = 64
) (
    input  logic                 clk,
    input  logic                 n_reset,
    mult_bus_sequencer_if.master bus,
    output logic                 busy
`ifdef SEQ_PERF_EN
    ,
    output logic [15:0]          perf_ops,
    output logic [15:0]          perf_tout
`endif
);

    localparam int PCW = $clog2(POLL_MAX + 1);
    localparam int GCW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
    localparam logic [PCW-1:0] POLL_LAST = PCW'(POLL_MAX - 1);
    localparam logic [GCW-1:0] GAP_LAST  = GCW'(POLL_GAP - 1);

    // Access phases
    localparam logic [1:0] PH_SETUP  = 2'd0;
    localparam logic [1:0] PH_STROBE = 2'd1;
    localparam logic [1:0] PH_HOLD   = 2'd2;

    typedef enum logic [3:0] {
        S_IDLE, S_WR_A1, S_WR_A2, S_WR_GO, S_GAP, S_POLL, S_RD_W, S_RD_L, S_OUT
    } state_t;

    state_t           state_reg, state_next;
    logic [1:0]       phase_reg, phase_next;
    logic [GCW-1:0]   gap_reg, gap_next;
    logic [PCW-1:0]   poll_cnt_reg, poll_cnt_next;
    logic [23:0]      a_reg, a_next;
    logic [23:0]      b_reg, b_next;
    logic [31:0]      res_w_reg, res_w_next;
    logic [5:0]       res_l_reg, res_l_next;
    logic             res_tout_reg, res_tout_next;

    logic [15:0]      acc_addr;
    logic [31:0]      acc_wdata;
    logic             acc_wr;
    logic             acc_rd;
    logic             hold_end;

    assign hold_end = (phase_reg == PH_HOLD);

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_reg    <= S_IDLE;
            phase_reg    <= PH_SETUP;
            gap_reg      <= '0;
            poll_cnt_reg <= '0;
            a_reg        <= '0;
            b_reg        <= '0;
            res_w_reg    <= '0;
            res_l_reg    <= '0;
            res_tout_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            phase_reg    <= phase_next;
            gap_reg      <= gap_next;
            poll_cnt_reg <= poll_cnt_next;
            a_reg        <= a_next;
            b_reg        <= b_next;
            res_w_reg    <= res_w_next;
            res_l_reg    <= res_l_next;
            res_tout_reg <= res_tout_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        phase_next    = phase_reg;
        gap_next      = gap_reg;
        poll_cnt_next = poll_cnt_reg;
        a_next        = a_reg;
        b_next        = b_reg;
        res_w_next    = res_w_reg;
        res_l_next    = res_l_reg;
        res_tout_next = res_tout_reg;
        acc_addr      = 16'h0000;
        acc_wdata     = 32'h0000_0000;
        acc_wr        = 1'b0;
        acc_rd        = 1'b0;

        case (state_reg)
            S_IDLE: begin
                if (bus.op_valid) begin
                    a_next        = bus.op_a;
                    b_next        = bus.op_b;
                    poll_cnt_next = '0;
                    phase_next    = PH_SETUP;
                    state_next    = S_WR_A1;
                end
            end
            S_WR_A1: begin
                acc_addr  = ADDR_A1;
                acc_wdata = {8'h00, a_reg};
                acc_wr    = 1'b1;
                if (hold_end) state_next = S_WR_A2;
            end
            S_WR_A2: begin
                acc_addr  = ADDR_A2;
                acc_wdata = {8'h00, b_reg};
                acc_wr    = 1'b1;
                if (hold_end) state_next = S_WR_GO;
            end
            S_WR_GO: begin
                acc_addr = ADDR_CTRL;
                acc_wr   = 1'b1;
                if (hold_end) begin
                    gap_next   = '0;
                    state_next = S_GAP;
                end
            end
            S_GAP: begin
                if (gap_reg == GAP_LAST) begin
                    state_next = S_POLL;
                end else begin
                    gap_next = gap_reg + 1'b1;
                end
            end
            S_POLL: begin
                acc_addr = ADDR_CTRL;
                acc_rd   = 1'b1;
                if (hold_end) begin
                    if (bus.sdata_rd[1:0] == 2'b11) begin
                        state_next = S_RD_W;
                    end else begin
                        poll_cnt_next = poll_cnt_reg + 1'b1;
                        // The poll just finished was the last one allowed.
                        if (poll_cnt_reg == POLL_LAST) begin
                            res_w_next    = 32'h0000_0000;
                            res_l_next    = 6'd0;
                            res_tout_next = 1'b1;
                            state_next    = S_OUT;
                        end else begin
                            gap_next   = '0;
                            state_next = S_GAP;
                        end
                    end
                end
            end
            S_RD_W: begin
                acc_addr = ADDR_W;
                acc_rd   = 1'b1;
                if (hold_end) begin
                    res_w_next = bus.sdata_rd;
                    state_next = S_RD_L;
                end
            end
            S_RD_L: begin
                acc_addr = ADDR_L;
                acc_rd   = 1'b1;
                if (hold_end) begin
                    res_l_next    = bus.sdata_rd[5:0];
                    res_tout_next = 1'b0;
                    state_next    = S_OUT;
                end
            end
            S_OUT: begin
                if (bus.res_ready) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase

        // Shared access phase sequencer; wraps to setup for the next access.
        if (acc_wr || acc_rd) begin
            phase_next = hold_end ? PH_SETUP : phase_reg + 2'd1;
        end
    end

    assign bus.saddress  = acc_addr;
    assign bus.sdata_wr  = acc_wdata;
    assign bus.swr       = acc_wr && (phase_reg == PH_STROBE);
    assign bus.srd       = acc_rd && (phase_reg == PH_STROBE);
    assign bus.op_ready  = (state_reg == S_IDLE);
    assign bus.res_valid = (state_reg == S_OUT);
    assign bus.res_w     = res_w_reg;
    assign bus.res_l     = res_l_reg;
    assign bus.res_tout  = res_tout_reg;
    assign busy          = (state_reg != S_IDLE);

`ifdef SEQ_PERF_EN
    logic [15:0] perf_ops_reg;
    logic [15:0] perf_tout_reg;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            perf_ops_reg  <= '0;
            perf_tout_reg <= '0;
        end else if ((state_reg == S_OUT) && bus.res_ready) begin
            if (res_tout_reg) perf_tout_reg <= perf_tout_reg + 16'd1;
            else              perf_ops_reg  <= perf_ops_reg + 16'd1;
        end
    end

    assign perf_ops  = perf_ops_reg;
    assign perf_tout = perf_tout_reg;
`endif

endmodule

// File: tb/tb_mult_bus_sequencer.sv
// ----------------------------------------------------------------------------
// tb_mult_bus_sequencer
// Self-checking bench for mult_bus_sequencer with a behavioural model of the
// multiplier/popcount peripheral. Operand pairs come from a vector table;
// expected results are queued when an operand pair is driven and compared
// when the result handshake happens. Reset corner cases are hand-written.
// ----------------------------------------------------------------------------
module tb_mult_bus_sequencer;
    localparam int          G    = 4;
    localparam int          PM   = 64;
    localparam logic [15:0] A_A1 = 16'h0380;
    localparam logic [15:0] A_A2 = 16'h0388;
    localparam logic [15:0] A_W  = 16'h0390;
    localparam logic [15:0] A_L  = 16'h0398;
    localparam logic [15:0] A_CT = 16'h03A0;
    localparam int          NV   = 8;

    logic clk = 1'b0;
    logic n_reset;
    logic busy;
`ifdef SEQ_PERF_EN
    logic [15:0] perf_ops;
    logic [15:0] perf_tout;
`endif

    mult_bus_sequencer_if bus_if ();

    always #5 clk = ~clk;

    mult_bus_sequencer #(.POLL_GAP(G), .POLL_MAX(PM)) dut (
        .clk      (clk),
        .n_reset  (n_reset),
        .bus      (bus_if),
        .busy     (busy)
`ifdef SEQ_PERF_EN
        ,
        .perf_ops (perf_ops),
        .perf_tout(perf_tout)
`endif
    );

    // ---------------- peripheral model ----------------
    typedef struct packed {
        logic [15:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t         wr_log[$];
    logic [31:0] m_a1, m_a2;
    logic [63:0] m_prod;
    int          done_after = 1;   // 0: never done
    int          ctrl_base  = 0;
    int          ctrl_reads = 0;
    int          w_reads    = 0;
    int          l_reads    = 0;
    int          proto_err  = 0;
    logic        strobe_q   = 1'b0;

    assign m_prod = m_a1 * m_a2;

    always @(posedge clk) begin
        if (bus_if.swr) begin
            wr_log.push_back('{addr: bus_if.saddress, data: bus_if.sdata_wr});
            if (bus_if.saddress == A_A1) m_a1 <= bus_if.sdata_wr;
            if (bus_if.saddress == A_A2) m_a2 <= bus_if.sdata_wr;
        end
        if (bus_if.srd) begin
            if (bus_if.saddress == A_CT) begin
                ctrl_reads <= ctrl_reads + 1;
                if (done_after != 0 && (ctrl_reads + 1 - ctrl_base) >= done_after)
                    bus_if.sdata_rd <= {30'h2AAA_AAAA, 2'b11};
                else if (done_after == 0 || ctrl_reads[0])
                    bus_if.sdata_rd <= {30'h1555_5555, 2'b01};
                else
                    bus_if.sdata_rd <= {30'h1555_5555, 2'b10};
            end else if (bus_if.saddress == A_W) begin
                w_reads <= w_reads + 1;
                bus_if.sdata_rd <= m_prod[31:0];
            end else if (bus_if.saddress == A_L) begin
                l_reads <= l_reads + 1;
                bus_if.sdata_rd <= {26'h2AA_AAAA, 6'($countones(m_prod[31:0]))};
            end else begin
                bus_if.sdata_rd <= 32'hDEAD_BEEF;
            end
        end
    end

    // Strobes never together and never two cycles in a row.
    always @(posedge clk) begin
        if (bus_if.swr && bus_if.srd) proto_err <= proto_err + 1;
        else if ((bus_if.swr || bus_if.srd) && strobe_q) proto_err <= proto_err + 1;
        strobe_q <= bus_if.swr || bus_if.srd;
    end

    // ---------------- checking ----------------
    typedef struct {
        logic [23:0] a;
        logic [23:0] b;
        int          done_after;
        int          stall;
        logic [31:0] w;
        logic [5:0]  l;
        logic        tout;
    } vec_t;

    typedef struct {
        logic [31:0] w;
        logic [5:0]  l;
        logic        tout;
    } exp_t;

    vec_t vecs[NV];
    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   exp_ops  = 0;
    int   exp_tout = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input int i);
        vec_t v;
        exp_t e;
        int   lat, n, exp_lat, exp_polls, cb, wb, lb;
        wr_t  w0, w1, w2;
        v = vecs[i];
        done_after = v.done_after;
        cb = ctrl_reads; wb = w_reads; lb = l_reads;
        ctrl_base = cb;
        @(negedge clk);
        bus_if.op_valid = 1'b1;
        bus_if.op_a     = v.a;
        bus_if.op_b     = v.b;
        sb.push_back('{w: v.w, l: v.l, tout: v.tout});
        n = 0;
        while (!bus_if.op_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("op_ready_wait", bus_if.op_ready, 1);
        @(posedge clk);
        #1;
        bus_if.op_valid = 1'b0;
        bus_if.op_a     = 24'($urandom);
        bus_if.op_b     = 24'($urandom);
        chk("busy_after_accept", busy, 1);
        chk("op_ready_after_accept", bus_if.op_ready, 0);
        lat = 0;
        while (!bus_if.res_valid && lat < 2000) begin
            @(posedge clk);
            #1;
            lat++;
        end
        exp_polls = v.tout ? PM : v.done_after;
        exp_lat   = v.tout ? (12 + G + (PM - 1) * (G + 3))
                           : (18 + G + (exp_polls - 1) * (G + 3));
        chk("latency", lat, exp_lat);
        if (v.stall > 0) begin
            if (i + 1 < NV) begin
                bus_if.op_valid = 1'b1;
                bus_if.op_a     = vecs[i+1].a;
                bus_if.op_b     = vecs[i+1].b;
            end
            for (int k = 0; k < v.stall; k++) begin
                @(negedge clk);
                chk("stall_res_valid", bus_if.res_valid, 1);
                chk("stall_op_ready", bus_if.op_ready, 0);
                chk("stall_res_w", bus_if.res_w, v.w);
                chk("stall_res_l", bus_if.res_l, v.l);
            end
        end
        @(negedge clk);
        bus_if.res_ready = 1'b1;
        e = sb.pop_front();
        chk("res_valid", bus_if.res_valid, 1);
        chk("res_w", bus_if.res_w, e.w);
        chk("res_l", bus_if.res_l, e.l);
        chk("res_tout", bus_if.res_tout, e.tout);
        @(posedge clk);
        #1;
        bus_if.res_ready = 1'b0;
        if (v.tout) exp_tout++;
        else        exp_ops++;
        chk("res_valid_drop", bus_if.res_valid, 0);
        chk("op_ready_after_hs", bus_if.op_ready, 1);
        chk("ctrl_reads", ctrl_reads - cb, exp_polls);
        chk("w_reads", w_reads - wb, v.tout ? 0 : 1);
        chk("l_reads", l_reads - lb, v.tout ? 0 : 1);
        chk("wr_count", wr_log.size(), 3);
        if (wr_log.size() >= 3) begin
            w0 = wr_log.pop_front();
            w1 = wr_log.pop_front();
            w2 = wr_log.pop_front();
            chk("wr_a1", {w0.addr, w0.data}, {A_A1, 8'h00, v.a});
            chk("wr_a2", {w1.addr, w1.data}, {A_A2, 8'h00, v.b});
            chk("wr_go", {w2.addr, w2.data}, {A_CT, 32'h0});
        end
        wr_log.delete();
        $display("txn %0d a=%06h b=%06h w=%08h l=%0d tout=%0b latency=%0d polls=%0d",
                 i, v.a, v.b, e.w, e.l, e.tout, lat, ctrl_reads - cb);
    endtask

    initial begin
        int n;
        vecs[0] = '{24'd3,       24'd5,       1,  0,  32'd15,        6'd4, 1'b0};
        vecs[1] = '{24'hFFFFFF,  24'hFFFFFF,  1,  0,  32'hFE000001,  6'd8, 1'b0};
        vecs[2] = '{24'd3,       24'd5,       0,  0,  32'd0,         6'd0, 1'b1};
        vecs[3] = '{24'd1000,    24'd1000,    3,  10, 32'h000F4240,  6'd7, 1'b0};
        vecs[4] = '{24'd2,       24'd7,       1,  0,  32'd14,        6'd3, 1'b0};
        vecs[5] = '{24'h800000,  24'h000200,  2,  0,  32'd0,         6'd0, 1'b0};
        vecs[6] = '{24'h123456,  24'h000100,  64, 0,  32'h12345600,  6'd9, 1'b0};
        vecs[7] = '{24'd0,       24'd123,     1,  0,  32'd0,         6'd0, 1'b0};

        n_reset          = 1'b0;
        bus_if.op_valid  = 1'b0;
        bus_if.op_a      = '0;
        bus_if.op_b      = '0;
        bus_if.res_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_op_ready", bus_if.op_ready, 1);
        chk("rst_res_valid", bus_if.res_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_strobes", {bus_if.swr, bus_if.srd}, 0);
        chk("rst_saddress", bus_if.saddress, 0);
        chk("rst_sdata_wr", bus_if.sdata_wr, 0);
        chk("rst_res", {bus_if.res_w, bus_if.res_l, bus_if.res_tout}, 0);
        n_reset = 1'b1;

        // Reset asserted while a write strobe is high.
        done_after = 0;
        @(negedge clk);
        bus_if.op_valid = 1'b1;
        bus_if.op_a     = 24'd9;
        bus_if.op_b     = 24'd9;
        @(posedge clk);
        #1 bus_if.op_valid = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus_if.swr && n < 50);
        repeat (3) @(negedge clk);   // next access (A2) strobe
        chk("mid_swr_seen", bus_if.swr, 1);
        #2 n_reset = 1'b0;
        #1;
        chk("mid_rst_strobes", {bus_if.swr, bus_if.srd}, 0);
        chk("mid_rst_op_ready", bus_if.op_ready, 1);
        chk("mid_rst_res_valid", bus_if.res_valid, 0);
        chk("mid_rst_busy", busy, 0);
        @(negedge clk);
        n_reset = 1'b1;
        wr_log.delete();
        repeat (8) @(negedge clk);
        chk("mid_rst_no_rewrite", wr_log.size(), 0);
        chk("mid_rst_idle", busy, 0);

        // Reset while a result is pending in OUT.
        done_after = 1;
        ctrl_base  = ctrl_reads;
        @(negedge clk);
        bus_if.op_valid = 1'b1;
        bus_if.op_a     = 24'd4;
        bus_if.op_b     = 24'd4;
        @(posedge clk);
        #1 bus_if.op_valid = 1'b0;
        n = 0;
        while (!bus_if.res_valid && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("pend_res_valid", bus_if.res_valid, 1);
        chk("pend_res_w", bus_if.res_w, 32'd16);
        #2 n_reset = 1'b0;
        #1;
        chk("pend_rst_res_valid", bus_if.res_valid, 0);
        chk("pend_rst_op_ready", bus_if.op_ready, 1);
        @(negedge clk);
        n_reset = 1'b1;
        wr_log.delete();
        repeat (6) @(negedge clk);
        chk("pend_discarded", bus_if.res_valid, 0);
        chk("pend_no_rewrite", wr_log.size(), 0);

        for (int i = 0; i < NV; i++) run_vec(i);

        chk("protocol", proto_err, 0);
        chk("sb_empty", sb.size(), 0);
`ifdef SEQ_PERF_EN
        chk("perf_ops", perf_ops, exp_ops);
        chk("perf_tout", perf_tout, exp_tout);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
